// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter/sequencer time-sharing one external combinational ALU.
// Optional macro ALU_SHARE_FIXED_PRIO_EN: requester 0 always wins contention (no round-robin pointer).
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [OP_WIDTH-1:0]   req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [OP_WIDTH-1:0]   req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_result,
    output logic                  rsp0_zero,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_result,
    output logic                  rsp1_zero,
    output logic [OP_WIDTH-1:0]   alu_control,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic [CNT_WIDTH-1:0]  ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q;
    logic                  owner_q;
    logic [OP_WIDTH-1:0]   op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] res_q;
    logic                  zero_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
`ifndef ALU_SHARE_FIXED_PRIO_EN
    logic                  ptr_q;
`endif

    logic grant1;
    logic rsp_fire;

    always_comb begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
        grant1 = req1_valid && !req0_valid;
`else
        // ptr_q names the requester favoured when both are valid
        grant1 = req1_valid && (!req0_valid || ptr_q);
`endif
        req0_ready = (state_q == IDLE) && req0_valid && !grant1;
        req1_ready = (state_q == IDLE) && grant1;
        rsp0_valid = (state_q == RESP) && !owner_q;
        rsp1_valid = (state_q == RESP) && owner_q;
        rsp_fire   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
    end

    assign rsp0_result = res_q;
    assign rsp1_result = res_q;
    assign rsp0_zero   = zero_q;
    assign rsp1_zero   = zero_q;
    assign alu_control = op_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign ops_done    = cnt_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        owner_q <= grant1;
                        op_q    <= grant1 ? req1_op : req0_op;
                        a_q     <= grant1 ? req1_a  : req0_a;
                        b_q     <= grant1 ? req1_b  : req0_b;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    res_q   <= alu_result;
                    zero_q  <= alu_zero;
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_fire) begin
                        state_q <= IDLE;
                        cnt_q   <= cnt_q + CNT_WIDTH'(1);
`ifndef ALU_SHARE_FIXED_PRIO_EN
                        ptr_q   <= ~owner_q;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: directed test-plan scenarios plus random traffic against a transaction-level model.
module tb_alu_share_arbiter;

    localparam int DW = 32;
    localparam int OW = 5;
    localparam int CW = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          v0, v1, rr0, rr1;
    logic [OW-1:0] op0, op1;
    logic [DW-1:0] a0, b0, a1, b1;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
    logic [DW-1:0] rsp0_result, rsp1_result, alu_a, alu_b, alu_result;
    logic [OW-1:0] alu_control;
    logic          alu_zero;
    logic [CW-1:0] ops_done;

    always #5 Clk = ~Clk;

    alu_share_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .CNT_WIDTH(CW)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0_valid(v0), .req0_ready(req0_ready), .req0_op(op0), .req0_a(a0), .req0_b(b0),
        .req1_valid(v1), .req1_ready(req1_ready), .req1_op(op1), .req1_a(a1), .req1_b(b1),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rr0), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rr1), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero), .ops_done(ops_done)
    );

    // Stand-in ALU: returns {zero, result}; beq reports equality in both fields
    function automatic logic [DW:0] alu_ref(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic          z;
        case (op)
            5'd0:    r = a + b;
            5'd1:    r = a - b;
            5'd4:    r = a & b;
            5'd5:    r = a | b;
            5'd17:   r = (a == b) ? 32'd1 : 32'd0;
            default: r = a ^ b;
        endcase
        z = (op == 5'd17) ? (a == b) : (r == '0);
        return {z, r};
    endfunction

    assign {alu_zero, alu_result} = alu_ref(alu_control, alu_a, alu_b);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding op, response due one cycle after the EXEC cycle
    bit            m_busy, m_owner, m_ptr;
    int unsigned   m_age, m_done;
    logic [OW-1:0] m_op;
    logic [DW-1:0] m_a, m_b;
    logic [DW:0]   m_exp;
    bit            acc0, acc1;
    int            grants[$];
    logic [DW-1:0] results[$];

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_age = 0; m_done = 0;
        m_op = '0; m_a = '0; m_b = '0; m_exp = '0;
    endtask

    task automatic tick();
        bit w1, e_rdy0, e_rdy1, e_rv0, e_rv1, done;
        logic [CW-1:0] e_cnt;
        #1;
`ifdef ALU_SHARE_FIXED_PRIO_EN
        w1 = v1 && !v0;
`else
        w1 = v1 && (!v0 || m_ptr);
`endif
        e_rdy0 = !m_busy && v0 && !w1;
        e_rdy1 = !m_busy && w1;
        e_rv0  = m_busy && m_age >= 1 && !m_owner;
        e_rv1  = m_busy && m_age >= 1 && m_owner;
        e_cnt  = m_done[CW-1:0];
        chk("req0_ready", 32'(req0_ready), 32'(e_rdy0));
        chk("req1_ready", 32'(req1_ready), 32'(e_rdy1));
        chk("rsp0_valid", 32'(rsp0_valid), 32'(e_rv0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(e_rv1));
        chk("alu_control", 32'(alu_control), 32'(m_op));
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("ops_done", 32'(ops_done), 32'(e_cnt));
        if (e_rv0) begin
            chk("rsp0_result", rsp0_result, m_exp[DW-1:0]);
            chk("rsp0_zero", 32'(rsp0_zero), 32'(m_exp[DW]));
        end
        if (e_rv1) begin
            chk("rsp1_result", rsp1_result, m_exp[DW-1:0]);
            chk("rsp1_zero", 32'(rsp1_zero), 32'(m_exp[DW]));
        end
        acc0 = e_rdy0;
        acc1 = e_rdy1;
        done = (e_rv0 && rr0) || (e_rv1 && rr1);
        @(posedge Clk);
        if (done) begin
            m_busy = 0;
            m_ptr  = ~m_owner;
            m_done++;
            results.push_back(m_exp[DW-1:0]);
        end else if (m_busy) begin
            m_age++;
        end
        if (e_rdy0 || e_rdy1) begin
            m_busy  = 1;
            m_age   = 0;
            m_owner = e_rdy1;
            m_op    = e_rdy1 ? op1 : op0;
            m_a     = e_rdy1 ? a1 : a0;
            m_b     = e_rdy1 ? b1 : b0;
            m_exp   = alu_ref(m_op, m_a, m_b);
            grants.push_back(e_rdy1 ? 1 : 0);
        end
        @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [OW-1:0] pick_op();
        case ($urandom_range(0, 5))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd4;
            3: return 5'd5;
            4: return 5'd17;
            default: return OW'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        int exp_g[4];
        logic [DW-1:0] exp_r[4];
        logic [DW-1:0] held;
        Reset = 1'b0;
        v0 = 0; v1 = 0; rr0 = 0; rr1 = 0;
        op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        model_reset();
        do_reset();

        // reset state
        #1;
        chk("rst_rv0", 32'(rsp0_valid), 32'd0);
        chk("rst_rdy1", 32'(req1_ready), 32'd0);
        chk("rst_ctl", 32'(alu_control), 32'd0);
        chk("rst_res", rsp0_result, 32'd0);
        chk("rst_done", 32'(ops_done), 32'd0);
        @(negedge Clk);

        // reset asserted during EXEC of req0
        v0 = 1; op0 = 5'd0; a0 = 1; b0 = 1; rr0 = 1;
        tick();
        v0 = 0;
        #2 Reset = 1'b1;
        #1;
        chk("mid_rv0", 32'(rsp0_valid), 32'd0);
        chk("mid_rdy0", 32'(req0_ready), 32'd0);
        chk("mid_alu_a", alu_a, 32'd0);
        chk("mid_alu_b", alu_b, 32'd0);
        chk("mid_done", 32'(ops_done), 32'd0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
        repeat (5) tick();

        // single add on req0
        v0 = 1; op0 = 5'd0; a0 = 5; b0 = 7; rr0 = 1;
        tick();
        v0 = 0;
        tick();
        #1;
        chk("single_valid", 32'(rsp0_valid), 32'd1);
        chk("single_res", rsp0_result, 32'd12);
        chk("single_zero", 32'(rsp0_zero), 32'd0);
        tick();
        #1 chk("single_done", 32'(ops_done), 32'd1);

        // beq on req1
        v1 = 1; op1 = 5'd17; a1 = 32'h1234; b1 = 32'h1234; rr1 = 1;
        tick();
        v1 = 0;
        tick();
        #1;
        chk("beq_res", rsp1_result, 32'd1);
        chk("beq_zero", 32'(rsp1_zero), 32'd1);
        chk("beq_rv0", 32'(rsp0_valid), 32'd0);
        repeat (2) tick();

        // contention with both requesters held valid
        grants.delete(); results.delete();
        v0 = 1; op0 = 5'd1; a0 = 10;    b0 = 3;     rr0 = 1;
        v1 = 1; op1 = 5'd4; a1 = 'hF0;  b1 = 'h3C;  rr1 = 1;
`ifdef ALU_SHARE_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
        exp_r = '{32'd7, 32'd7, 32'd7, 32'd7};
`else
        exp_g = '{0, 1, 0, 1};
        exp_r = '{32'd7, 32'h30, 32'd7, 32'h30};
`endif
        repeat (12) tick();
        v0 = 0; v1 = 0;
        chk("cont_ngrant", 32'(grants.size()), 32'd4);
        chk("cont_nres", 32'(results.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size() && i < results.size(); i++) begin
            chk($sformatf("cont_grant%0d", i), 32'(grants[i]), 32'(exp_g[i]));
            chk($sformatf("cont_res%0d", i), results[i], exp_r[i]);
        end
        #1 chk("cont_done", 32'(ops_done), 32'd6);
        repeat (2) tick();

        // backpressure on rsp0 while req1 waits
        v0 = 1; op0 = 5'd0; a0 = 100; b0 = 23; rr0 = 0;
        v1 = 1; op1 = 5'd5; a1 = 1;   b1 = 2;  rr1 = 1;
        tick();
        v0 = 0;
        tick();
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_hold", rsp0_result, 32'd123);
            chk("bp_rdy1", 32'(req1_ready), 32'd0);
            tick();
        end
        rr0 = 1;
        tick();
        #1 chk("bp_grant1", 32'(req1_ready), 32'd1);
        tick();
        v1 = 0;
        repeat (3) tick();

        // counter wrap: 17 ops on a 4-bit counter
        do_reset();
        rr0 = 1;
        for (int i = 0; i < 17; i++) begin
            v0 = 1; op0 = pick_op(); a0 = $urandom; b0 = $urandom;
            tick();
            v0 = 0;
            repeat (2) tick();
        end
        #1 chk("wrap_done", 32'(ops_done), 32'd1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if (!(v0 && !acc0)) begin
                v0 = ($urandom_range(0, 2) != 0);
                op0 = pick_op(); a0 = $urandom;
                b0 = $urandom_range(0, 3) == 0 ? a0 : $urandom;
            end
            if (!(v1 && !acc1)) begin
                v1 = ($urandom_range(0, 2) != 0);
                op1 = pick_op(); a1 = $urandom;
                b1 = $urandom_range(0, 3) == 0 ? a1 : $urandom;
            end
            rr0 = ($urandom_range(0, 9) < 7);
            rr1 = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter and sequencer that time-shares a single external ALU32Bit instance between two clients, for example the motion-estimation SAD datapath and a secondary address-generation path. It accepts operations over valid/ready request ports, selects one winner, drives the ALU from registered operands, captures the result and zero flag, and returns them on a per-requester valid/ready response port. It contains no arithmetic of its own; every computation goes through the shared ALU.

## Interface
Parameters:
- DATA_WIDTH, 32, operand and result width
- OP_WIDTH, 5, ALU control code width (matches the ALU's 5-bit ALUControl encoding)
- CNT_WIDTH, 16, width of the completed-operation counter

Ports:
- Clk  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- reqN_valid  in  1  (N = 0, 1) requester N has an operation pending
- reqN_ready  out  1  requester N's operation is accepted this cycle
- reqN_op  in  OP_WIDTH  ALU control code
- reqN_a, reqN_b  in  DATA_WIDTH  operands A and B
- rspN_valid  out  1  result available for requester N
- rspN_ready  in  1  requester N consumes its result
- rspN_result  out  DATA_WIDTH  captured ALU_Result
- rspN_zero  out  1  captured Zero flag
- alu_control  out  OP_WIDTH  to ALU ALUControl
- alu_a, alu_b  out  DATA_WIDTH  to ALU A and B
- alu_result  in  DATA_WIDTH  from ALU ALU_Result
- alu_zero  in  1  from ALU Zero
- ops_done  out  CNT_WIDTH  count of completed response handshakes

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no reqN_valid is high, the FSM stays in IDLE.
  - Otherwise the arbiter computes a grant combinationally and raises reqN_ready only for the winner.
  - On that handshake it latches op, a and b into the operand registers, records the owner, and moves to EXEC.
- EXEC: the ALU settles on the registered operands for one full cycle. At the end of the cycle, alu_result and alu_zero are captured into the result registers, and the FSM moves to RESP.
- RESP:
  - rspN_valid is high only for the owner.
  - rspN_result and rspN_zero hold the captured values.
  - When the owner's rspN_ready is high, the FSM returns to IDLE, the priority pointer is set to the requester that did not own the operation, and ops_done increments.
- Arbitration:
  - Round-robin. When both requesters are valid, the requester named by the priority pointer wins.
  - When one requester is valid, it wins regardless of the pointer.
  - The pointer changes only on response completion.
- alu_control, alu_a and alu_b always reflect the operand registers. They hold their value between operations.
- reqN_ready is never high outside IDLE. A request that arrives during EXEC or RESP waits.
- Once asserted, rspN_valid stays high, with stable data, until rspN_ready is seen.
- ops_done wraps from all-ones to 0. No flag accompanies the wrap.

## Timing
- Reset values:
  - FSM state IDLE; priority pointer 0.
  - Operand registers 0, so the ALU sees add with A=0, B=0.
  - Result registers 0; owner 0; ops_done 0.
  - All reqN_ready and rspN_valid outputs 0.
- Reset asserted mid-operation drops the in-flight operation and its result. No response is issued, and after release the FSM is in IDLE.
- Latency is fixed: request handshake in cycle T, EXEC in T+1, rspN_valid first high in T+2.
- Minimum issue interval is 3 cycles, reached when rspN_ready is already high in the first RESP cycle.
- If rspN_ready is held low, RESP lasts indefinitely. The other requester is stalled for that whole time; this is intended, because the ALU holds the owner's operands.
- The ALU is treated as purely combinational with a path under one clock period. EXEC is the single settle cycle.

## Configuration
- Macro: ALU_SHARE_FIXED_PRIO_EN.
- Defined: fixed priority. Requester 0 always wins when both requesters are valid, and the priority pointer logic is removed.
- Undefined (default): round-robin arbitration as described under Operation.

## Test plan
- Single op: req0 with op=00000, a=5, b=7, rsp0_ready held high → rsp0_valid high 2 cycles after the handshake, result=12, zero=0; ops_done=1.
- Branch flag: req1 with op=10001 (beq), a=b=0x1234 → rsp1_result=1, rsp1_zero=1; rsp0_valid stays 0 throughout.
- Contention, round-robin, both requesters always valid, rsp ready high:
  - Grants after reset go 0, 1, 0, 1.
  - req0 uses op=00001 with a=10, b=3; req1 uses op=00100 with a=0xF0, b=0x3C.
  - Results alternate 7 and 0x30, and ops_done reaches 4.
- Backpressure:
  - Hold rsp0_ready low for 10 cycles after rsp0_valid rises → rsp0_result stays stable.
  - req1_ready stays 0 while req1_valid is high.
  - req1 is granted in the first IDLE cycle after rsp0_ready rises.
- Reset mid-op:
  - Assert Reset during EXEC of req0 (op=00000, a=1, b=1) → all outputs return to their reset values asynchronously.
  - No rsp0_valid appears after release, and ops_done=0.
- Counter wrap and macro:
  - With CNT_WIDTH=4, complete 17 operations → ops_done=1.
  - Rebuild with ALU_SHARE_FIXED_PRIO_EN and hold both requesters valid → requester 0 wins every grant.
